uart_host_sequencer: RTL
========================

// Module: uart_host_sequencer
// PURPOSE
//  On-board UART host initiator: the far end of tpu_top's UART command interface, driving TPU uart_rx and sampling TPU uart_tx.
//  Command bytes are queued, then sent 8N1 back-to-back on start.
//  A concurrent receiver captures the TPU's response bytes, with a response timeout.
//  Instantiated in the Basys3 top for switch/button-triggered self-test without a PC.
// PARAMETERS
//  CLOCK_FREQ      100_000_000  clk frequency in Hz
//  BAUD_RATE       115200       line rate; CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE (integer division, truncated)
//  CMD_DEPTH       16           command FIFO depth in bytes (power of 2)
//  RESP_BYTES      4            response bytes captured before done
//  TIMEOUT_CYCLES  1_000_000    idle cycles before timeout_err
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous, active-high reset
//  cmd_wr_en    in   1   push cmd_wr_data into command FIFO
//  cmd_wr_data  in   8   command byte
//  cmd_full     out  1   FIFO holds CMD_DEPTH bytes
//  start        in   1   one-cycle pulse: begin transaction
//  busy         out  1   transaction in progress
//  host_tx      out  1   serial out to TPU uart_rx (idle high)
//  host_rx      in   1   serial in from TPU uart_tx (asynchronous)
//  resp_idx     in   $clog2(RESP_BYTES)  response byte select
//  resp_data    out  8   response byte [resp_idx], combinational read
//  resp_count   out  $clog2(RESP_BYTES+1)  valid response bytes received
//  done         out  1   level; transaction finished (success or timeout)
//  timeout_err  out  1   sticky until next start; timeout ended transaction
//  frame_err    out  1   sticky until next start; a received stop bit sampled 0
// BEHAVIOUR
//  Reset: host_tx=1, busy=0, done=0, timeout_err=0, frame_err=0, resp_count=0, all resp bytes=0x00.
//   Reset also empties the FIFO (cmd_full=0), returns both FSMs to idle and aborts any frame mid-bit (host_tx=1 next cycle).
//  FIFO: write accepted iff cmd_wr_en && !busy && !cmd_full. Writes while busy or full are dropped silently.
//   A write in the same cycle as start is accepted and transmitted.
//  start is honoured only when !busy; otherwise ignored.
//   On honoured start at edge T: busy=1, done=0, errors, resp_count and resp bytes cleared, all effective from T+1.
//  TX FSM: TX_IDLE -> TX_START -> TX_DATA -> TX_STOP.
//   If the FIFO is non-empty, host_tx falls at T+1.
//   Each bit lasts CLKS_PER_BIT cycles. Data is sent LSB first, 10 bit times per byte.
//   After TX_STOP, the next byte's start bit follows immediately if the FIFO is non-empty, otherwise TX_IDLE.
//   start with an empty FIFO skips TX and only receives.
//  RX: host_rx passes a 2-flop synchronizer. RX is armed only while busy, so it runs concurrently with TX.
//   RX_IDLE: a falling edge of the synced line -> RX_START.
//   RX_START: re-check at CLKS_PER_BIT/2; if the line is high, false start -> RX_IDLE.
//   RX_DATA: 8 samples at CLKS_PER_BIT intervals from mid-start, stored LSB first.
//   RX_STOP: sample at mid-stop.
//    Stop=1: store byte at index resp_count, resp_count++.
//    Stop=0: discard byte, set frame_err, resp_count unchanged.
//   Bytes arriving after resp_count==RESP_BYTES are ignored.
//  Timeout counter: cleared on start, on TX completion and on every accepted or discarded RX byte.
//   Counts only once TX is idle and the FIFO is empty.
//  Completion when TX is idle with the FIFO empty and RX is in RX_IDLE:
//   If resp_count==RESP_BYTES -> busy=0, done=1 on the next cycle.
//   Else if the counter reaches TIMEOUT_CYCLES -> timeout_err=1, busy=0, done=1 on the same next cycle.
//   done holds until the next honoured start or rst.
//  An RX frame in progress at timeout is abandoned.
// TESTING (bench params CLOCK_FREQ=16, BAUD_RATE=1 -> CLKS_PER_BIT=16, RESP_BYTES=2, TIMEOUT_CYCLES=100)
//  1. Loopback host_tx->host_rx; write 0xA5,0x3C; start -> host_tx = 0,1,0,1,0,0,1,0,1,1 per 16 cycles.
//     Then resp[0]=0xA5, resp[1]=0x3C, resp_count=2, done=1, timeout_err=0.
//  2. Write 17 bytes while idle -> cmd_full=1 after 16th; 17th dropped; start -> exactly 16 frames (160 bit times).
//  3. host_rx held 1, one command byte -> done=1 and timeout_err=1 exactly 101 cycles after stop bit end; resp_count=0.
//  4. Inject frame 0x55 with stop bit 0, then valid 0x12, 0x34 -> frame_err=1, resp[0]=0x12, resp[1]=0x34, done=1.
//  5. 4-cycle low glitch on host_rx -> no byte captured; start pulse while busy -> ignored, no re-clear.
//  6. Assert rst mid TX_DATA -> next cycle host_tx=1, busy=0, cmd_full=0.
//     A following start with an empty FIFO and no RX input -> timeout path only.

Source files
------------

// File: rtl/uart_host_sequencer.sv
// UART host initiator: queues command bytes, sends them 8N1 back-to-back on start,
// and captures RESP_BYTES response bytes concurrently, ending on success or idle timeout.
module uart_host_sequencer #(
    parameter int CLOCK_FREQ     = 100_000_000,
    parameter int BAUD_RATE      = 115200,
    parameter int CMD_DEPTH      = 16,
    parameter int RESP_BYTES     = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_wr_en,
    input  logic [7:0]                      cmd_wr_data,
    output logic                            cmd_full,
    input  logic                            start,
    output logic                            busy,
    output logic                            host_tx,
    input  logic                            host_rx,
    input  logic [$clog2(RESP_BYTES)-1:0]   resp_idx,
    output logic [7:0]                      resp_data,
    output logic [$clog2(RESP_BYTES+1)-1:0] resp_count,
    output logic                            done,
    output logic                            timeout_err,
    output logic                            frame_err,
    output logic [1:0]                      tx_state_dbg,
    output logic [1:0]                      rx_state_dbg
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int BIT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW     = $clog2(CMD_DEPTH);
    localparam int IDX_W  = $clog2(RESP_BYTES);
    localparam int RC_W   = $clog2(RESP_BYTES + 1);
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] HALF_LAST = BIT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [RC_W-1:0]  RC_MAX    = RC_W'(RESP_BYTES);
    localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t        tx_state, tx_state_n;
    logic [BIT_W-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]       tx_bit, tx_bit_n;
    logic [7:0]       tx_shift, tx_shift_n;
    logic             tx_line_n, tx_fin, fifo_pop;

    rx_state_t        rx_state, rx_state_n;
    logic [BIT_W-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]       rx_bit, rx_bit_n;
    logic [7:0]       rx_shift, rx_shift_n;
    logic             rx_ok, rx_bad;
    logic             rx_s1, rx_s2, rx_prev;

    logic [7:0]       fifo_mem [CMD_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, fifo_level;
    logic             fifo_empty, fifo_push;
    logic [7:0]       fifo_rdata;

    logic [7:0]       resp_mem [RESP_BYTES];
    logic [TMR_W-1:0] tmr;
    logic             start_ok, quiet, finish_ok, finish_to;

    // Command write handshake: cmd_wr_en is valid, (!busy && !cmd_full) is ready;
    // the byte is taken on the edge where both hold, otherwise it is dropped.
    assign fifo_level = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign cmd_full   = (fifo_level == (AW+1)'(CMD_DEPTH));
    assign fifo_push  = cmd_wr_en && !busy && !cmd_full;
    assign fifo_rdata = fifo_mem[rd_ptr[AW-1:0]];

    assign start_ok  = start && !busy;
    assign quiet     = busy && (tx_state == TX_IDLE) && fifo_empty && (rx_state == RX_IDLE);
    assign finish_ok = quiet && (resp_count == RC_MAX);
    assign finish_to = quiet && (tmr == TMR_MAX);

    assign tx_state_dbg = tx_state;
    assign rx_state_dbg = rx_state;

    always_comb begin
        resp_data = 8'h00;
        for (int i = 0; i < RESP_BYTES; i++)
            if (resp_idx == IDX_W'(i)) resp_data = resp_mem[i];
    end

    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr[AW-1:0]] <= cmd_wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (fifo_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + BIT_W'(1);
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_line_n  = host_tx;
        tx_fin     = 1'b0;
        fifo_pop   = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_n  = '0;
                tx_line_n = 1'b1;
                if ((start_ok || busy) && !fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_shift_n = fifo_rdata;
                    tx_state_n = TX_START;
                    tx_line_n  = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = 3'd0;
                    tx_state_n = TX_DATA;
                    tx_line_n  = tx_shift[0];
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    if (tx_bit == 3'd7) begin
                        tx_state_n = TX_STOP;
                        tx_line_n  = 1'b1;
                    end else begin
                        tx_bit_n   = tx_bit + 3'd1;
                        tx_shift_n = {1'b0, tx_shift[7:1]};
                        tx_line_n  = tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        tx_shift_n = fifo_rdata;
                        tx_state_n = TX_START;
                        tx_line_n  = 1'b0;
                    end else begin
                        tx_state_n = TX_IDLE;
                        tx_fin     = 1'b1;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    // Receiver samples the synchronized line at mid-bit, counting from the detected falling edge.
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + BIT_W'(1);
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_ok      = 1'b0;
        rx_bad     = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (rx_prev && !rx_s2) rx_state_n = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = 3'd0;
                    rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_s2, rx_shift[7:1]};
                    rx_bit_n   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_state_n = RX_IDLE;
                    rx_ok      = rx_s2;
                    rx_bad     = !rx_s2;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
        if (!busy) begin
            rx_state_n = RX_IDLE;
            rx_ok      = 1'b0;
            rx_bad     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'h00;
            host_tx  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'h00;
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            host_tx  <= tx_line_n;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
            rx_s1    <= host_rx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            frame_err   <= 1'b0;
            resp_count  <= '0;
            tmr         <= '0;
            for (int i = 0; i < RESP_BYTES; i++) resp_mem[i] <= 8'h00;
        end else if (start_ok) begin
            busy        <= 1'b1;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            frame_err   <= 1'b0;
            resp_count  <= '0;
            tmr         <= '0;
            for (int i = 0; i < RESP_BYTES; i++) resp_mem[i] <= 8'h00;
        end else if (busy) begin
            if (finish_ok || finish_to) begin
                busy        <= 1'b0;
                done        <= 1'b1;
                timeout_err <= !finish_ok;
            end
            if (rx_ok && (resp_count < RC_MAX)) begin
                for (int i = 0; i < RESP_BYTES; i++)
                    if (resp_count == RC_W'(i)) resp_mem[i] <= rx_shift;
                resp_count <= resp_count + RC_W'(1);
            end
            if (rx_bad) frame_err <= 1'b1;
            // The timer only runs once nothing is left to send; any finished frame restarts it.
            if (tx_fin || rx_ok || rx_bad)
                tmr <= '0;
            else if ((tx_state == TX_IDLE) && fifo_empty && (tmr != TMR_MAX))
                tmr <= tmr + TMR_W'(1);
        end
    end
endmodule
